// File: rtl/vwb_sequencer.sv
// vwb_sequencer: splits wide vector writebacks into 128-bit VRF beats and broadcasts scalar writes.
// Define VWB_PERF_CNT_EN to add the stall_cycles/beats_issued counters.
module vwb_sequencer #(
  parameter int DATA_W = 512,
  parameter int BEAT_W = 128,
  parameter int RD_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  output logic              wb_ready,
  output logic              stall,
  input  logic              WVRwrite_in,
  input  logic              SVRwrite_in,
  input  logic [RD_W-1:0]   rd_in,
  input  logic [1:0]        VL_in,
  input  logic [DATA_W-1:0] readdata512_in,
  input  logic [31:0]       alu_result_in,
  output logic              vrf_we,
  output logic [RD_W-1:0]   vrf_addr,
  output logic [1:0]        vrf_beat,
  output logic [BEAT_W-1:0] vrf_wdata,
  output logic              err_conflict
`ifdef VWB_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       beats_issued
`endif
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state;
  logic [1:0] remaining;
  logic [DATA_W-1:0] buffer;
  logic accept;
  // The burst returns to IDLE on the edge that issues its last beat, so a new
  // instruction is accepted while that beat is on the port and follows with no bubble.
  assign wb_ready = state == IDLE;
  assign stall = ~wb_ready;
  assign accept = wb_valid & wb_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      remaining <= '0;
      buffer <= '0;
      vrf_we <= 1'b0;
      vrf_addr <= '0;
      vrf_beat <= '0;
      vrf_wdata <= '0;
      err_conflict <= 1'b0;
    end else if (accept && WVRwrite_in) begin
      vrf_we <= 1'b1;
      vrf_addr <= rd_in;
      vrf_beat <= '0;
      vrf_wdata <= readdata512_in[BEAT_W-1:0];
      buffer <= readdata512_in >> BEAT_W;
      remaining <= VL_in;
      state <= VL_in != 2'd0 ? BURST : IDLE;
      if (SVRwrite_in) err_conflict <= 1'b1;
    end else if (accept && SVRwrite_in) begin
      vrf_we <= 1'b1;
      vrf_addr <= rd_in;
      vrf_beat <= '0;
      vrf_wdata <= {(BEAT_W/32){alu_result_in}};
      state <= IDLE;
    end else if (state == BURST) begin
      vrf_we <= 1'b1;
      vrf_beat <= vrf_beat + 2'd1;
      vrf_wdata <= buffer[BEAT_W-1:0];
      buffer <= buffer >> BEAT_W;
      remaining <= remaining - 2'd1;
      state <= remaining == 2'd1 ? IDLE : BURST;
    end else begin
      vrf_we <= 1'b0;
    end
  end
`ifdef VWB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      beats_issued <= '0;
    end else begin
      if (wb_valid && stall && stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
      if (vrf_we) beats_issued <= beats_issued + 32'd1;
    end
  end
`endif
endmodule
